pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/pipeline_stall_ctrl_load_use_detect.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall controller.
package stall_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    EX_WAIT  = 2'd2
  } state_t;

  // Default memory-wait watchdog limit, in MEM_WAIT cycles.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds an ID source.
// Register 0 is hardwired and never creates a dependency.
module load_use_detect #(
  parameter int unsigned REG_W = 4
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_dreg,
  input  logic [REG_W-1:0] id_areg,
  input  logic [REG_W-1:0] id_breg,
  output logic             hazard
);

  // Pure compare; no state.
  always_comb begin
    hazard = ex_is_load && (ex_dreg != '0) &&
             ((ex_dreg == id_areg) || (ex_dreg == id_breg));
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes and
// multi-cycle memory / execute waits, with a stall-cycle counter.
// Optional memory-wait watchdog: define STALL_TIMEOUT_EN.
module pipeline_stall_ctrl
  import stall_pkg::*;
#(
  parameter int unsigned REG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_dreg,
  input  logic [REG_W-1:0] id_areg,
  input  logic [REG_W-1:0] id_breg,
  input  logic             branch_taken,
  input  logic             mem_start,
  input  logic             mem_done,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  output logic             pc_hold,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             hold_ex_mem,
  output logic             hold_mem_wb,
  output logic             clear_if_id,
  output logic             clear_id_ex,
  output logic             clear_ex_mem,
  output logic             clear_mem_wb,
  output logic [31:0]      stall_cnt,
  output logic             timeout_err
);

  state_t state, state_nx;
  logic   pending_flush, pending_nx;
  logic   hazard;
  logic   wait_mem, wait_ex;
  logic   timeout_hit;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_is_load (ex_is_load),
    .ex_dreg    (ex_dreg),
    .id_areg    (id_areg),
    .id_breg    (id_breg),
    .hazard     (hazard)
  );

`ifdef STALL_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_q;

  assign timeout_hit = (state == MEM_WAIT) && !mem_done &&
                       (wait_cnt == TIMEOUT_CYCLES - 32'd1);
  assign timeout_err = timeout_q;

  // Count consecutive MEM_WAIT cycles; latch a sticky error on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == MEM_WAIT) && !mem_done && !timeout_hit)
        wait_cnt <= wait_cnt + 32'd1;
      else
        wait_cnt <= '0;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State, deferred-flush flag and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pending_flush <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_nx;
      pending_flush <= pending_nx;
      if (pc_hold)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Next state plus hold/clear decode. The start cycle of a wait already
  // behaves as the wait state, so a branch in that cycle is deferred too.
  always_comb begin
    state_nx     = state;
    pending_nx   = pending_flush;
    pc_hold      = 1'b0;
    hold_if_id   = 1'b0;
    hold_id_ex   = 1'b0;
    hold_ex_mem  = 1'b0;
    hold_mem_wb  = 1'b0;
    clear_if_id  = 1'b0;
    clear_id_ex  = 1'b0;
    clear_ex_mem = 1'b0;
    clear_mem_wb = 1'b0;

    wait_mem = (state == MEM_WAIT) || ((state == IDLE) && mem_start);
    wait_ex  = (state == EX_WAIT) ||
               ((state == IDLE) && !mem_start && ex_mc_start);

    case (state)
      IDLE: begin
        if (mem_start)        state_nx = MEM_WAIT;
        else if (ex_mc_start) state_nx = EX_WAIT;
      end
      MEM_WAIT: begin
        if (mem_done || timeout_hit) state_nx = IDLE;
      end
      EX_WAIT: begin
        if (ex_mc_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (wait_mem) begin
      pc_hold      = 1'b1;
      hold_if_id   = 1'b1;
      hold_id_ex   = 1'b1;
      hold_ex_mem  = 1'b1;
      clear_mem_wb = 1'b1;
      pending_nx   = pending_flush || branch_taken;
    end else if (wait_ex) begin
      pc_hold      = 1'b1;
      hold_if_id   = 1'b1;
      hold_id_ex   = 1'b1;
      clear_ex_mem = 1'b1;
      pending_nx   = pending_flush || branch_taken;
    end else if (branch_taken || pending_flush) begin
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      pending_nx   = 1'b0;
    end else if (hazard) begin
      pc_hold      = 1'b1;
      hold_if_id   = 1'b1;
      clear_id_ex  = 1'b1;
    end

    if (reset) begin
      state_nx     = IDLE;
      pending_nx   = 1'b0;
      pc_hold      = 1'b1;
      hold_if_id   = 1'b0;
      hold_id_ex   = 1'b0;
      hold_ex_mem  = 1'b0;
      hold_mem_wb  = 1'b0;
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_ex_mem = 1'b1;
      clear_mem_wb = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
// Timeout scenario is exercised when STALL_TIMEOUT_EN is defined.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_is_load;
  logic [3:0]  ex_dreg, id_areg, id_breg;
  logic        branch_taken, mem_start, mem_done, ex_mc_start, ex_mc_done;
  logic        pc_hold, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb;
  logic        clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
  logic [31:0] stall_cnt;
  logic        timeout_err;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          mon_en  = 1'b0;

  pipeline_stall_ctrl #(.REG_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_dreg(ex_dreg),
    .id_areg(id_areg), .id_breg(id_breg), .branch_taken(branch_taken),
    .mem_start(mem_start), .mem_done(mem_done), .ex_mc_start(ex_mc_start),
    .ex_mc_done(ex_mc_done), .pc_hold(pc_hold), .hold_if_id(hold_if_id),
    .hold_id_ex(hold_id_ex), .hold_ex_mem(hold_ex_mem),
    .hold_mem_wb(hold_mem_wb), .clear_if_id(clear_if_id),
    .clear_id_ex(clear_id_ex), .clear_ex_mem(clear_ex_mem),
    .clear_mem_wb(clear_mem_wb), .stall_cnt(stall_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [8:0] ctrl;
  assign ctrl = {pc_hold, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb,
                 clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: 0 = free, 1 = waiting on memory, 2 = waiting on multi-cycle EX
  int          m_busy = 0;
  int          m_mem_len = 0;
  bit          m_pend = 0;
  bit          m_err = 0;
  logic [31:0] m_cnt = 0;

  // Compare outputs to the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [8:0] e;
      bit starting_mem, starting_ex, hz;
      e = '0;
      starting_mem = (m_busy == 0) && mem_start;
      starting_ex  = (m_busy == 0) && !mem_start && ex_mc_start;
      hz = ex_is_load && (ex_dreg != 0) && (ex_dreg == id_areg || ex_dreg == id_breg);
      if (reset)
        e = 9'b1_0000_1111;
      else if (m_busy == 1 || starting_mem)
        e = 9'b1_1110_0001;
      else if (m_busy == 2 || starting_ex)
        e = 9'b1_1100_0010;
      else if (branch_taken || m_pend)
        e = 9'b0_0000_1100;
      else if (hz)
        e = 9'b1_1000_0100;
      chk("ctrl", {23'd0, ctrl}, {23'd0, e});
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});

      if (reset) begin
        m_busy = 0; m_mem_len = 0; m_pend = 0; m_err = 0; m_cnt = 0;
      end else begin
        if (m_busy != 0 || starting_mem || starting_ex)
          m_pend = m_pend | branch_taken;
        else
          m_pend = 0;
        m_cnt = m_cnt + {31'd0, e[8]};
        if (m_busy == 0) begin
          if (mem_start) begin m_busy = 1; m_mem_len = 0; end
          else if (ex_mc_start) m_busy = 2;
        end else if (m_busy == 1) begin
          if (mem_done) m_busy = 0;
          else begin
            m_mem_len++;
`ifdef STALL_TIMEOUT_EN
            if (m_mem_len == TO) begin m_busy = 0; m_err = 1; end
`endif
          end
        end else begin
          if (ex_mc_done) m_busy = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_cycle();
    @(posedge clk); #1;
    reset = 0; ex_is_load = 0; ex_dreg = 0; id_areg = 0; id_breg = 0;
    branch_taken = 0; mem_start = 0; mem_done = 0; ex_mc_start = 0; ex_mc_done = 0;
  endtask

  task automatic end_cycle();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin begin_cycle(); end_cycle(); end
  endtask

  task automatic do_reset();
    begin_cycle(); reset = 1; end_cycle();
  endtask

  initial begin
    reset = 1; ex_is_load = 0; ex_dreg = 0; id_areg = 0; id_breg = 0;
    branch_taken = 0; mem_start = 0; mem_done = 0; ex_mc_start = 0; ex_mc_done = 0;
    @(posedge clk); #1;
    mon_en = 1;
    end_cycle();
    // reset state
    chk("rst_ctrl", {23'd0, ctrl}, 32'h10F);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);

    // load-use
    begin_cycle(); ex_is_load = 1; ex_dreg = 3; id_areg = 1; id_breg = 3; end_cycle();
    chk("lu_stall", {29'd0, pc_hold, hold_if_id, clear_id_ex}, 32'd7);
    begin_cycle(); end_cycle();
    chk("lu_one_cycle", {31'd0, pc_hold}, 32'd0);
    chk("lu_cnt", stall_cnt, 32'd1);
    begin_cycle(); ex_is_load = 1; end_cycle();
    chk("lu_r0", {31'd0, pc_hold}, 32'd0);

    // memory wait: start, done 5 cycles later
    do_reset();
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      mem_start = (i == 0);
      mem_done  = (i == 5);
      end_cycle();
      chk("mw_hold", {30'd0, pc_hold, clear_mem_wb}, 32'd3);
    end
    begin_cycle(); end_cycle();
    chk("mw_release", {31'd0, pc_hold}, 32'd0);
    chk("mw_cnt", stall_cnt, 32'd6);

    // deferred flush
    do_reset();
    for (int i = 0; i < 7; i++) begin
      begin_cycle();
      ex_mc_start  = (i == 0);
      branch_taken = (i == 2);
      ex_mc_done   = (i == 4);
      end_cycle();
      if (i == 2) chk("df_held", {23'd0, ctrl}, 32'h1C2);
      if (i == 5) chk("df_flush", {23'd0, ctrl}, 32'h00C);
      if (i == 6) chk("df_once", {23'd0, ctrl}, 32'h000);
    end

    // simultaneous starts; branch beats load-use
    do_reset();
    begin_cycle(); mem_start = 1; ex_mc_start = 1; end_cycle();
    chk("sim_mem", {23'd0, ctrl}, 32'h1E1);
    begin_cycle(); ex_mc_done = 1; end_cycle();
    chk("sim_ign", {23'd0, ctrl}, 32'h1E1);
    begin_cycle(); mem_done = 1; end_cycle();
    begin_cycle(); ex_is_load = 1; ex_dreg = 2; id_areg = 2; branch_taken = 1; end_cycle();
    chk("br_lu", {23'd0, ctrl}, 32'h00C);

    // reset mid-wait
    do_reset();
    begin_cycle(); mem_start = 1; end_cycle();
    begin_cycle(); end_cycle();
    do_reset();
    begin_cycle(); mem_done = 1; end_cycle();
    chk("rmw_free", {23'd0, ctrl}, 32'h000);
    begin_cycle(); ex_mc_done = 1; end_cycle();
    chk("rmw_free2", {23'd0, ctrl}, 32'h000);
    chk("rmw_cnt", stall_cnt, 32'd0);

    // watchdog
    do_reset();
    begin_cycle(); mem_start = 1; end_cycle();
    idle(8);
`ifdef STALL_TIMEOUT_EN
    chk("to_err_wait", {31'd0, timeout_err}, 32'd0);
    begin_cycle(); end_cycle();
    chk("to_idle", {31'd0, pc_hold}, 32'd0);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    begin_cycle(); mem_start = 1; end_cycle();
    begin_cycle(); mem_done = 1; end_cycle();
    idle(3);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
`else
    idle(12);
    chk("nto_hold", {31'd0, pc_hold}, 32'd1);
    chk("nto_err", {31'd0, timeout_err}, 32'd0);
    begin_cycle(); mem_done = 1; end_cycle();
    begin_cycle(); end_cycle();
    chk("nto_release", {31'd0, pc_hold}, 32'd0);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      begin_cycle();
      reset        = ($urandom_range(0, 149) == 0);
      ex_is_load   = $urandom_range(0, 1) == 1;
      ex_dreg      = 4'($urandom_range(0, 3));
      id_areg      = 4'($urandom_range(0, 3));
      id_breg      = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_start    = ($urandom_range(0, 9) == 0);
      mem_done     = ($urandom_range(0, 5) == 0);
      ex_mc_start  = ($urandom_range(0, 9) == 0);
      ex_mc_done   = ($urandom_range(0, 3) == 0);
      end_cycle();
    end

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
